// File: rtl/sumator_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the bit-counter width helper.
package sumator_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter only has to reach width-1, so $clog2 bits suffice; keep at least one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sumator_serial_ctrl_if.sv
// Operand and result handshake bundle of the bit-serial adder controller.
// master = producer/consumer side, slave = controller side.
interface sumator_serial_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/sumator_serial_ctrl_sumator.sv
// Single full-adder cell reused every cycle by the serial controller,
// composed of two half adders.
module sumator_serial_ctrl_sumator (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s_h0;
  logic c_h0;
  logic c_h1;

  sumator_serial_ctrl_semisumator u_h0 (
    .a (a),
    .b (b),
    .s (s_h0),
    .c (c_h0)
  );

  sumator_serial_ctrl_semisumator u_h1 (
    .a (s_h0),
    .b (ci),
    .s (s),
    .c (c_h1)
  );

  assign co = c_h0 | c_h1;

endmodule

module sumator_serial_ctrl_semisumator (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/sumator_serial_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in
// LSB first over WIDTH cycles using one full-adder cell.
module sumator_serial_ctrl
  import sumator_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sumator_serial_ctrl_if.slave bus
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] opa_q,       opa_d;
  logic [WIDTH-1:0] opb_q,       opb_d;
  logic [WIDTH-1:0] res_q,       res_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             carry_q,     carry_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  logic cell_s;
  logic cell_co;
  logic last_bit;

  sumator_serial_ctrl_sumator u_cell (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  assign last_bit = (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {cell_s, res_q[WIDTH-1:1]};
        carry_d = cell_co;
        if (last_bit) begin
          // carry_q is the carry into the MSB at this point; the visible
          // result registers only move here so they hold outside DONE.
          sum_d   = {cell_s, res_q[WIDTH-1:1]};
          cout_d  = cell_co;
          ovf_d   = carry_q ^ cell_co;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next-state decode, so
    // neither in_valid nor out_ready reaches an output combinationally.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule
